// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and tick pacing.
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready word load,
//        shift_en tick, ser_out/ser_valid/ser_first/ser_last serial side, busy.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             at_last;
    logic             accept;

    assign at_last = (state == SHIFT) && (cnt == LAST);

    // Ready early on the last tick so a waiting word follows with no gap.
    assign in_ready = !rst && ((state == IDLE) || (at_last && shift_en));
    assign accept   = in_valid && in_ready;

    // The transmitted bit always sits at the output end of sreg.
    assign sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
            sreg  <= in_data;
        end else if ((state == SHIFT) && shift_en) begin
            if (at_last) begin
                // sreg cleared so ser_out reads 0 while idle.
                state <= IDLE;
                cnt   <= '0;
                sreg  <= '0;
            end else begin
                cnt  <= cnt + CW'(1);
                sreg <= sreg_nxt;
            end
        end
    end

    assign ser_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign ser_valid = (state == SHIFT);
    assign ser_first = ser_valid && (cnt == '0);
    assign ser_last  = at_last;
    assign busy      = ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers driven in parallel
// and compared each cycle against a frame/bit-index reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       shift_en;

    logic rdy_m, out_m, val_m, fst_m, lst_m, bsy_m;
    logic rdy_l, out_l, val_l, fst_l, lst_l, bsy_l;

    int vec  = 0;
    int miss = 0;

    // Reference model: whether a frame is on the line, its word, bit index.
    bit       m_act  = 1'b0;
    bit [7:0] m_word = '0;
    int       m_idx  = 0;

    logic [11:0] obs;
    logic [11:0] exp;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .shift_en(shift_en), .ser_out(out_m),
        .ser_valid(val_m), .ser_first(fst_m), .ser_last(lst_m),
        .busy(bsy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .shift_en(shift_en), .ser_out(out_l),
        .ser_valid(val_l), .ser_first(fst_l), .ser_last(lst_l),
        .busy(bsy_l)
    );

    // Drive one cycle; record observed ready (pre-edge) and outputs
    // (post-edge) in obs, and the model's prediction in exp.
    task automatic step(input logic r, input logic v,
                        input logic [7:0] d, input logic se);
        logic rdy;
        logic bm, bl;
        rst = r; in_valid = v; in_data = d; shift_en = se;
        #1;
        rdy = !r && (!m_act || (m_idx == 7 && se));
        obs[11:10] = {rdy_m, rdy_l};
        exp[11:10] = {rdy, rdy};
        if (r) begin
            m_act = 1'b0;
            m_idx = 0;
        end else if (v && rdy) begin
            m_act  = 1'b1;
            m_word = d;
            m_idx  = 0;
        end else if (m_act && se) begin
            if (m_idx == 7) m_act = 1'b0;
            else m_idx++;
        end
        @(posedge clk);
        #1;
        bm = m_act ? m_word[7 - m_idx] : 1'b0;
        bl = m_act ? m_word[m_idx] : 1'b0;
        obs[9:0] = {out_m, val_m, fst_m, lst_m, bsy_m,
                    out_l, val_l, fst_l, lst_l, bsy_l};
        exp[9:0] = {bm, m_act, m_act && m_idx == 0, m_act && m_idx == 7, m_act,
                    bl, m_act, m_act && m_idx == 0, m_act && m_idx == 7, m_act};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h5A, 1'b1);
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL reset cyc%0d got %b want %b", i, obs, exp);
            end
        end
        vec++;
        if ({val_m, out_m, fst_m, lst_m, bsy_m, val_l, out_l} !== 7'b0) begin
            miss++;
            $display("FAIL reset_outs got %b want 0",
                     {val_m, out_m, fst_m, lst_m, bsy_m, val_l, out_l});
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        vec++;
        if (obs[11:10] !== 2'b11 || obs !== exp) begin
            miss++;
            $display("FAIL reset_release got %b want %b", obs, exp);
        end
    endtask

    task automatic test_single();
        logic [7:0] acc = '0;
        int nf = 0, nl = 0, lastpos = -1;
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL single cyc%0d got %b want %b", c, obs, exp);
            end
            if (c <= 8) acc = {acc[6:0], out_m};
            if (fst_m) nf++;
            if (lst_m) begin nl++; lastpos = c; end
            if (c < 9) step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        vec++;
        if (acc !== 8'hA5 || nf != 1 || nl != 1 || lastpos != 8) begin
            miss++;
            $display("FAIL single_seq got %h f%0d l%0d@%0d want a5 f1 l1@8",
                     acc, nf, nl, lastpos);
        end
        vec++;
        if (val_m !== 1'b0 || out_m !== 1'b0) begin
            miss++;
            $display("FAIL single_end got v%b o%b want v0 o0", val_m, out_m);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        vec++;
        if (obs !== exp || rdy_m !== 1'b1) begin
            miss++;
            $display("FAIL single_idle got %b want %b", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] acc = '0;
        int nv = 0;
        logic [1:0] fpos = '0;
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL b2b cyc%0d got %b want %b", c, obs, exp);
            end
            if (c <= 16) begin
                acc = {acc[14:0], out_m};
                if (val_m) nv++;
            end
            if (fst_m && c == 1) fpos[0] = 1'b1;
            if (fst_m && c == 9) fpos[1] = 1'b1;
            if (c <= 7) step(1'b0, 1'b1, 8'h3C, 1'b1);
            else if (c == 8) begin
                step(1'b0, 1'b1, 8'h3C, 1'b1);
                vec++;
                if (obs[11] !== 1'b1) begin
                    miss++;
                    $display("FAIL b2b_ready got %b want 1", obs[11]);
                end
            end else step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        vec++;
        if (acc !== 16'hA53C || nv != 16 || fpos !== 2'b11) begin
            miss++;
            $display("FAIL b2b_seq got %h v%0d f%b want a53c v16 f11",
                     acc, nv, fpos);
        end
    endtask

    task automatic test_tick_pacing();
        logic [31:0] acc = '0;
        int nv = 0, nl = 0;
        step(1'b0, 1'b1, 8'hF0, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL tick cyc%0d got %b want %b", c, obs, exp);
            end
            if (val_m) begin
                acc = {acc[30:0], out_m};
                nv++;
            end
            if (lst_m) nl++;
            step(1'b0, 1'b0, 8'h00, (c % 4) == 0);
        end
        vec++;
        if (acc !== 32'hFFFF0000 || nv != 32 || nl != 4) begin
            miss++;
            $display("FAIL tick_seq got %h v%0d l%0d want ffff0000 v32 l4",
                     acc, nv, nl);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] acc = '0;
        step(1'b0, 1'b1, 8'h01, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL lsb cyc%0d got %b want %b", c, obs, exp);
            end
            acc = {acc[6:0], out_l};
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        vec++;
        if (acc !== 8'h80) begin
            miss++;
            $display("FAIL lsb_seq got %b want 10000000", acc);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] acc = '0;
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        vec++;
        if (obs !== exp ||
            {out_m, val_m, fst_m, lst_m, bsy_m, out_l, val_l} !== 7'b0) begin
            miss++;
            $display("FAIL midrst got %b want %b", obs, exp);
        end
        step(1'b0, 1'b1, 8'h81, 1'b0);
        acc = {acc[6:0], out_m};
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 8'(c * 8'h35 + 8'h1), 1'b0);
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL stall cyc%0d got %b want %b", c, obs, exp);
            end
        end
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 1'b0, 8'hFF, 1'b1);
            acc = {acc[6:0], out_m};
        end
        vec++;
        if (acc !== 8'h81 || obs !== exp) begin
            miss++;
            $display("FAIL midrst_seq got %h want 81", acc);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                 8'($urandom), $urandom_range(0, 2) != 0);
            vec++;
            if (obs !== exp) begin
                miss++;
                $display("FAIL rand cyc%0d got %b want %b", c, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; shift_en = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_tick_pacing();
        test_lsb_first();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter: accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per enabled clock edge, with framing flags.
It is the transmit end of the team's serial bit path; the receive end is the existing D-flop-based capture/shift chain.
It supports a shift-enable (baud/tick) input and back-to-back words with no idle gap.

Parameters:
WIDTH, 8, word width in bits (legal values: WIDTH >= 2)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous, active-high reset
in_data  input  WIDTH  parallel word, sampled only on handshake
in_valid  input  1  producer has a word
in_ready  output  1  block accepts in_data this cycle
shift_en  input  1  advance serial stream one bit at this edge
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out carries a frame bit
ser_first  output  1  ser_out is bit 0 of the frame sequence
ser_last  output  1  ser_out is the final frame bit
busy  output  1  frame in progress (equals ser_valid)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: at the rising edge of clk with rst=1, all outputs are forced to 0 next cycle and the block enters IDLE:
  - state=IDLE, cnt=0, shift register=0.
  - ser_out, ser_valid, ser_first, ser_last and busy are 0.
  - in_ready is 0 while rst=1.
- Reset mid-frame aborts the frame. Remaining bits are discarded and nothing resumes after reset.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=1 only when cnt==WIDTH-1 and shift_en=1. This combinational term allows a back-to-back load.
- Handshake: a word is accepted at the edge where in_valid=1 and in_ready=1. in_data is ignored at all other times, and a held in_valid with in_ready=0 is simply stalled.
- IDLE + accept (the edge where in_valid & in_ready) -> SHIFT with outputs next cycle:
  - shift register=in_data, cnt=0.
  - ser_valid=1, ser_first=1.
  - ser_out = in_data[WIDTH-1] if MSB_FIRST=1, else in_data[0].
  - Latency from accept to first bit is 1 cycle.
- SHIFT, shift_en=0: all state and outputs hold.
- SHIFT, shift_en=1, cnt<WIDTH-1: cnt increments, the next bit is presented and ser_first=0.
- SHIFT, shift_en=1, cnt==WIDTH-1:
  - in_valid=1: load the new word exactly as from IDLE (cnt=0, ser_first=1). ser_valid stays 1, so there is no gap.
  - in_valid=0: go to IDLE with ser_valid=0 and ser_out=0.
- ser_last = ser_valid & (cnt==WIDTH-1).
- shift_en is ignored in IDLE.
- Each bit is held for an integer number of cycles, ending at the first edge with shift_en=1.
- cnt width = clog2(WIDTH). cnt never exceeds WIDTH-1 and needs no wrap arithmetic.

Test Plan:
- Reset: rst=1 for 3 cycles with in_valid=1 -> in_ready=0 during rst; all outputs 0; in_ready=1 in the first cycle after rst drops; no word accepted while rst=1.
- Single word: WIDTH=8, MSB_FIRST=1, shift_en=1 constantly, in_data=0xA5 accepted at cycle 0 -> in cycles 1..8:
  - ser_out=1,0,1,0,0,1,0,1 with ser_valid=1.
  - ser_first=1 only in cycle 1 and ser_last=1 only in cycle 8.
  - Cycle 9: ser_valid=0, ser_out=0, in_ready=1.
- Back-to-back: 0xA5 then 0x3C with in_valid held -> in_ready=1 in cycle 8; ser_valid=1 for 16 contiguous cycles; cycles 9..16 carry 0,0,1,1,1,1,0,0; ser_first in cycles 1 and 9.
- Tick pacing: shift_en pulsed every 4th cycle, in_data=0xF0 -> each bit is held exactly 4 cycles; ser_last asserts for the final 4-cycle bit; frame length is 32 cycles.
- LSB-first: MSB_FIRST=0, in_data=0x01 -> serial sequence 1,0,0,0,0,0,0,0.
- Mid-frame reset and stall: rst asserted after 3 bits of 0xFF -> next cycle all outputs 0 and the state is IDLE. A new word 0x81 then transmits correctly from its first bit. in_data toggled while in_ready=0 does not alter the stream.
